// File: rtl/target_pin_arbiter.sv
// Target pin arbiter: hands the shared target programming/IO pins (nRST, MOSI,
// SCK, PDID, PDIC) to one requester at a time. The grant is registered and
// one-hot. A high-Z gap is inserted between owners. An owner that holds too
// long is revoked and locked out until it drops its request. Target power-off
// forces a release.
// Build option: define TPA_FIXED_PRIO_EN for fixed priority (lowest index
// wins) instead of round-robin.
module target_pin_arbiter #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned TO_W       = 16
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            target_highz_i,
    input  logic [TO_W-1:0] timeout_cfg_i,
    input  logic            timeout_clr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [2:0]      owner_o,
    output logic            pin_oe_o,
    output logic            busy_o,
    output logic            timeout_flag_o,
    output logic [NREQ-1:0] revoked_o
);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    localparam logic [NREQ-1:0] OneLsb  = NREQ'(1);
    localparam logic [7:0]      GapLast = 8'(GAP_CYCLES - 1);
    localparam logic [2:0]      LastIdx = 3'(NREQ - 1);
    localparam logic [TO_W-1:0] ToOne   = TO_W'(1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      owner_q, owner_d;
    logic [TO_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic            flag_q, flag_d;
    logic [NREQ-1:0] revoked_q, revoked_d;
`ifndef TPA_FIXED_PRIO_EN
    localparam logic [3:0] NreqW = 4'(NREQ);
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [3:0]      sel_sum;
`endif

    logic [NREQ-1:0]   eligible;
    logic [2*NREQ-1:0] rot;
    logic              sel_found;
    logic [2:0]        sel_off, sel_idx;
    logic              owner_req, to_hit, release_now;

    // Pick the winning requester among eligible ones.
    always_comb begin
        eligible = req_i & ~revoked_q;
`ifdef TPA_FIXED_PRIO_EN
        rot = {{NREQ{1'b0}}, eligible};
`else
        // Rotate so bit 0 is the requester at rr_ptr.
        rot = {eligible, eligible} >> rr_ptr_q;
`endif
        sel_found = 1'b0;
        sel_off   = 3'd0;
        // Descending scan so the lowest rotated offset wins.
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sel_found = 1'b1;
                sel_off   = 3'(i);
            end
        end
`ifdef TPA_FIXED_PRIO_EN
        sel_idx = sel_off;
`else
        sel_sum = {1'b0, rr_ptr_q} + {1'b0, sel_off};
        if (sel_sum >= NreqW) begin
            sel_sum = sel_sum - NreqW;
        end
        sel_idx = sel_sum[2:0];
`endif
    end

    // Release conditions for the current owner.
    always_comb begin
        owner_req   = |(req_i & grant_q);
        // >= so a lowered limit below the running count revokes at once.
        to_hit      = (timeout_cfg_i != '0) && (hold_cnt_q >= (timeout_cfg_i - ToOne));
        release_now = !owner_req || target_highz_i || to_hit;
    end

    // Next-state logic for the arbiter FSM and its sticky status.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        flag_d     = timeout_clr_i ? 1'b0 : flag_q;
        // A lockout lasts only until the requester is seen low.
        revoked_d  = revoked_q & req_i;
`ifndef TPA_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (sel_found && !target_highz_i) begin
                    state_d    = StGrant;
                    grant_d    = OneLsb << sel_idx;
                    owner_d    = sel_idx;
                    hold_cnt_d = '0;
                end
            end
            StGrant: begin
                if (release_now) begin
                    state_d   = StGap;
                    grant_d   = '0;
                    gap_cnt_d = 8'd0;
`ifndef TPA_FIXED_PRIO_EN
                    rr_ptr_d  = (owner_q == LastIdx) ? 3'd0 : owner_q + 3'd1;
`endif
                    // Lock out only a genuine stuck owner, not a release or power-off.
                    if (owner_req && !target_highz_i && to_hit) begin
                        flag_d    = 1'b1;
                        revoked_d = revoked_d | grant_q;
                    end
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + ToOne;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            owner_q    <= 3'd0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= 8'd0;
            flag_q     <= 1'b0;
            revoked_q  <= '0;
`ifndef TPA_FIXED_PRIO_EN
            rr_ptr_q   <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            flag_q     <= flag_d;
            revoked_q  <= revoked_d;
`ifndef TPA_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    // Outputs straight from registered state.
    always_comb begin
        grant_o        = grant_q;
        owner_o        = owner_q;
        pin_oe_o       = |grant_q;
        busy_o         = (state_q != StIdle);
        timeout_flag_o = flag_q;
        revoked_o      = revoked_q;
    end

endmodule

// File: tb/tb_target_pin_arbiter.sv
// Directed bench for target_pin_arbiter with default parameters
// (NREQ=3, GAP_CYCLES=8, TO_W=16).
module tb_target_pin_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [2:0]  req_i;
    logic        target_highz_i;
    logic [15:0] timeout_cfg_i;
    logic        timeout_clr_i;
    logic [2:0]  grant_o;
    logic [2:0]  owner_o;
    logic        pin_oe_o;
    logic        busy_o;
    logic        timeout_flag_o;
    logic [2:0]  revoked_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt;
    logic saw_grant;

    always #5 clk = ~clk;

    target_pin_arbiter dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .req_i          (req_i),
        .target_highz_i (target_highz_i),
        .timeout_cfg_i  (timeout_cfg_i),
        .timeout_clr_i  (timeout_clr_i),
        .grant_o        (grant_o),
        .owner_o        (owner_o),
        .pin_oe_o       (pin_oe_o),
        .busy_o         (busy_o),
        .timeout_flag_o (timeout_flag_o),
        .revoked_o      (revoked_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the arbiter to return to IDLE.
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!busy_o) break;
            tick();
        end
        check(tag, 32'(busy_o), 32'd0);
    endtask

    initial begin
        reset_i        = 1'b1;
        req_i          = 3'b000;
        target_highz_i = 1'b0;
        timeout_cfg_i  = 16'd0;
        timeout_clr_i  = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_owner", 32'(owner_o), 32'd0);
        check("rst_oe", 32'(pin_oe_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_flag", 32'(timeout_flag_o), 32'd0);
        check("rst_revoked", 32'(revoked_o), 32'd0);

        // Single request, one-clock latency.
        reset_i = 1'b0;
        req_i   = 3'b010;
        tick();
        check("g1_grant", 32'(grant_o), 32'b010);
        check("g1_owner", 32'(owner_o), 32'd1);
        check("g1_oe", 32'(pin_oe_o), 32'd1);
        check("g1_busy", 32'(busy_o), 32'd1);

        // Owner 1 drops with 0 and 2 pending: 9 dead clocks, then next after 1.
        req_i = 3'b101;
        tick();
        check("rel_grant", 32'(grant_o), 32'd0);
        check("rel_oe", 32'(pin_oe_o), 32'd0);
        cnt = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (grant_o != 3'b000) break;
            cnt++;
        end
        check("gap_len", 32'(cnt), 32'd9);
`ifdef TPA_FIXED_PRIO_EN
        check("rr_grant", 32'(grant_o), 32'b001);
`else
        check("rr_grant", 32'(grant_o), 32'b100);
        check("rr_owner", 32'(owner_o), 32'd2);
`endif

        // Timeout of 16 on requester 0.
        req_i = 3'b000;
        tick();
        wait_idle("idle_a");
        timeout_cfg_i = 16'd16;
        req_i         = 3'b001;
        tick();
        check("to_grant0", 32'(grant_o), 32'b001);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant_o != 3'b001) break;
            cnt++;
        end
        check("to_len", 32'(cnt), 32'd16);
        check("to_grant", 32'(grant_o), 32'd0);
        check("to_flag", 32'(timeout_flag_o), 32'd1);
        check("to_revoked", 32'(revoked_o), 32'b001);

        // Locked out while request stays high.
        saw_grant = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (grant_o != 3'b000) saw_grant = 1'b1;
        end
        check("lock_nogrant", 32'(saw_grant), 32'd0);
        check("lock_revoked", 32'(revoked_o), 32'b001);

        // Drop for one cycle clears the lockout; re-raise is granted.
        req_i = 3'b000;
        tick();
        check("unlock_revoked", 32'(revoked_o), 32'd0);
        req_i         = 3'b001;
        timeout_cfg_i = 16'd0;
        tick();
        check("regrant", 32'(grant_o), 32'b001);
        timeout_clr_i = 1'b1;
        tick();
        timeout_clr_i = 1'b0;
        check("clr_flag", 32'(timeout_flag_o), 32'd0);
        check("clr_grant", 32'(grant_o), 32'b001);

        // Power-off pulse during GRANT.
        target_highz_i = 1'b1;
        tick();
        check("hz_grant", 32'(grant_o), 32'd0);
        check("hz_revoked", 32'(revoked_o), 32'd0);
        check("hz_flag", 32'(timeout_flag_o), 32'd0);
        req_i     = 3'b111;
        saw_grant = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant_o != 3'b000) saw_grant = 1'b1;
        end
        check("hz_hold_nogrant", 32'(saw_grant), 32'd0);
        target_highz_i = 1'b0;
        tick();
`ifdef TPA_FIXED_PRIO_EN
        check("hz_after", 32'(grant_o), 32'b001);
`else
        check("hz_after", 32'(grant_o), 32'b010);
`endif

        // Long hold with timeout disabled; then max limit shows saturation.
        for (int i = 0; i < 70000; i++) tick();
`ifdef TPA_FIXED_PRIO_EN
        check("long_grant", 32'(grant_o), 32'b001);
`else
        check("long_grant", 32'(grant_o), 32'b010);
`endif
        check("long_flag", 32'(timeout_flag_o), 32'd0);
        timeout_cfg_i = 16'hffff;
        tick();
        check("sat_revoke", 32'(grant_o), 32'd0);
        check("sat_flag", 32'(timeout_flag_o), 32'd1);
`ifndef TPA_FIXED_PRIO_EN
        check("sat_revoked", 32'(revoked_o), 32'b010);

        // Timeout set coincident with clear: set wins, next clear takes effect.
        timeout_clr_i = 1'b1;
        tick();
        check("pre_clr", 32'(timeout_flag_o), 32'd0);
        timeout_clr_i = 1'b0;
        timeout_cfg_i = 16'd4;
        wait_idle("idle_b");
        tick();
        check("c_grant", 32'(grant_o), 32'b100);
        tick();
        tick();
        tick();
        timeout_clr_i = 1'b1;
        tick();
        check("c_set_wins", 32'(timeout_flag_o), 32'd1);
        check("c_grant_off", 32'(grant_o), 32'd0);
        check("c_revoked", 32'(revoked_o), 32'b110);
        tick();
        check("c_clear", 32'(timeout_flag_o), 32'd0);
        timeout_clr_i = 1'b0;
        timeout_cfg_i = 16'd0;

        // Reset mid-GRANT: grant drops at once, no GAP.
        wait_idle("idle_c");
        tick();
        check("r_grant", 32'(grant_o), 32'b001);
        reset_i = 1'b1;
        tick();
        check("r_grant_off", 32'(grant_o), 32'd0);
        check("r_busy", 32'(busy_o), 32'd0);
        check("r_revoked", 32'(revoked_o), 32'd0);
        reset_i = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
